// File: rtl/common_types_pkg.sv
// Shared types for the memory request arbiter in front of axi_controller.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN (see mem_req_arbiter.sv).
package common_types_pkg;

   // Number of arbitrated clients.
   localparam int ARB_NCLIENTS = 2;

   // Widths of the latched request. Keep these equal to the arbiter's
   // ADDR_W / DATA_W parameters.
   localparam int ARB_ADDR_W = 32;
   localparam int ARB_DATA_W = 32;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BUSY,
      ARB_RESP
   } arb_state_t;

   // Request held stable towards the controller for a whole transaction.
   typedef struct packed {
      logic                  read;
      logic [1:0]            write;
      logic [ARB_ADDR_W-1:0] addr;
      logic [ARB_DATA_W-1:0] store;
   } arb_req_t;

   // Build a latched request. A write takes precedence, so a client that
   // raises read and write together gets only the write.
   function automatic arb_req_t arb_make_req(
      input logic                  read,
      input logic [1:0]            write,
      input logic [ARB_ADDR_W-1:0] addr,
      input logic [ARB_DATA_W-1:0] store
   );
      arb_req_t r;
      r.read  = read & (write == 2'b00);
      r.write = write;
      r.addr  = addr;
      r.store = store;
      return r;
   endfunction

endpackage

// File: rtl/mem_req_arbiter.sv
// Two-client request arbiter driving the request side of axi_controller.
// Client 0 = data memory, client 1 = instruction fetch. One request is
// granted and latched at a time; completion is returned as a one-cycle
// response pulse to the granted client.
// Build macro MEM_ARB_ROUND_ROBIN_EN: alternate priority on simultaneous
// requests; when undefined client 0 always wins a tie.
module mem_req_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              c0_read,
   input  logic [1:0]        c0_write,
   input  logic [ADDR_W-1:0] c0_addr,
   input  logic [DATA_W-1:0] c0_store,
   output logic              c0_resp,
   input  logic              c1_read,
   input  logic [1:0]        c1_write,
   input  logic [ADDR_W-1:0] c1_addr,
   input  logic [DATA_W-1:0] c1_store,
   output logic              c1_resp,
   output logic [DATA_W-1:0] resp_load,
   output logic              m_read,
   output logic [1:0]        m_write,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_store,
   output logic              m_done,
   input  logic              m_ready,
   input  logic [DATA_W-1:0] m_load
);
   import common_types_pkg::*;

   arb_state_t        state_q, state_d;
   arb_req_t          req_q, req_d;
   logic              gnt_q, gnt_d;
   logic [DATA_W-1:0] load_q, load_d;
   logic              c0_valid, c1_valid;
   logic              win;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic              last_q, last_d;
`endif

   assign c0_valid  = c0_read | (c0_write != 2'b00);
   assign c1_valid  = c1_read | (c1_write != 2'b00);
   assign resp_load = load_q;

   // Next-state, grant selection and controller/client outputs.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      gnt_d   = gnt_q;
      load_d  = load_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d  = last_q;
      // On a tie the client that was not granted last time wins.
      if (c0_valid && c1_valid) win = ~last_q;
      else                      win = ~c0_valid;
`else
      // Fixed priority: client 1 only wins when client 0 is idle.
      win = ~c0_valid;
`endif
      m_read  = 1'b0;
      m_write = 2'b00;
      m_addr  = '0;
      m_store = '0;
      m_done  = 1'b0;
      c0_resp = 1'b0;
      c1_resp = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            if (c0_valid || c1_valid) begin
               gnt_d   = win;
               state_d = ARB_BUSY;
`ifdef MEM_ARB_ROUND_ROBIN_EN
               last_d  = win;
`endif
               if (win)
                  req_d = arb_make_req(c1_read, c1_write,
                                       ARB_ADDR_W'(c1_addr), ARB_DATA_W'(c1_store));
               else
                  req_d = arb_make_req(c0_read, c0_write,
                                       ARB_ADDR_W'(c0_addr), ARB_DATA_W'(c0_store));
            end
         end
         ARB_BUSY: begin
            // Controller sees only the latch, never the live client inputs.
            m_read  = req_q.read;
            m_write = req_q.write;
            m_addr  = ADDR_W'(req_q.addr);
            m_store = DATA_W'(req_q.store);
            m_done  = m_ready;
            if (m_ready) begin
               load_d  = m_load;
               state_d = ARB_RESP;
            end
         end
         ARB_RESP: begin
            c0_resp = ~gnt_q;
            c1_resp = gnt_q;
            state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // State, request latch, grant id and captured load data.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= ARB_IDLE;
         req_q   <= '0;
         gnt_q   <= 1'b0;
         load_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_q  <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         gnt_q   <= gnt_d;
         load_q  <= load_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_q  <= last_d;
`endif
      end
   end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Two-client front end that sits directly upstream of axi_controller and drives its request side (read/write/addr/store/done, ready/load).
- Port 0 is the data-memory client; port 1 is the instruction-fetch client.
- Grants one request at a time and latches it, so controller inputs stay stable for the whole AXI transaction.
- Acknowledges the controller with done and returns load data to the granted client as a one-cycle response pulse.

Parameters:
- ADDR_W, 32, address width of clients and controller
- DATA_W, 32, store/load data width

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- c0_read  in  1  client 0 read request (level, held until c0_resp)
- c0_write  in  2  client 0 write request; non-zero = write, code passed through unchanged
- c0_addr  in  ADDR_W  client 0 address
- c0_store  in  DATA_W  client 0 write data
- c0_resp  out  1  client 0 completion pulse
- c1_read, c1_write, c1_addr, c1_store, c1_resp  same as client 0, for client 1
- resp_load  out  DATA_W  read data, valid while cN_resp is high
- m_read  out  1  to controller read
- m_write  out  2  to controller write code
- m_addr  out  ADDR_W  to controller address
- m_store  out  DATA_W  to controller store data
- m_done  out  1  to controller completion acknowledge
- m_ready  in  1  from controller: transaction complete
- m_load  in  DATA_W  from controller read data

Behaviour:
- Request valid: cN_valid = cN_read | (cN_write != 0).
  - If both read and write are set on one client, the write wins and the read is dropped for that grant.
- Reset (nrst=0 at posedge): state IDLE, all latched registers cleared.
  - Outputs: m_read=0, m_write=0, m_addr=0, m_store=0, m_done=0, c0_resp=0, c1_resp=0, resp_load=0.
- States: IDLE, BUSY, RESP.
- IDLE:
  - m_* outputs are 0.
  - If any cN_valid, pick the winner by the priority rule, latch read/write/addr/store and the grant id, then go BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - m_read, m_write, m_addr, m_store are driven from the latch only, never from live client inputs.
  - m_done = m_ready, combinationally in the same cycle.
  - On m_ready: capture m_load into resp_load and go RESP.
- RESP (exactly one cycle):
  - Assert resp for the granted client only; resp_load holds the captured data; go IDLE.
  - For writes, resp_load is the captured m_load value and is don't-care to clients.
- Latency: request first seen in IDLE at cycle 0 → m_* valid at cycle 1 → m_ready at cycle k → cN_resp at cycle k+1. Minimum 3 cycles.
- Client rule: the client must deassert or replace its request in the cycle after cN_resp. A client still asserting in that IDLE cycle is treated as a new request.
- Priority (default): fixed, client 0 beats client 1 on a simultaneous request.
- Client inputs that change while BUSY or RESP are ignored.
  - A non-granted client's request remains pending and is evaluated at the next IDLE.
- Reset mid-transaction: return to IDLE immediately with no resp pulse. The controller shares nrst, so the outstanding transaction is abandoned.
- m_ready while in IDLE or RESP is ignored: m_done=0, no state change.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_grant register (reset value 1, so client 0 wins first).
  - On a simultaneous request, the client not granted last wins.
  - last_grant updates on every grant.
- Undefined: fixed priority to client 0; no last_grant register.

Decomposition:
- common_types_pkg gains:
  - arb_state_t enum {ARB_IDLE, ARB_BUSY, ARB_RESP}
  - typedef arb_req_t: struct of read, write[1:0], addr, store (the latched request)
  - localparam ARB_NCLIENTS = 2
- No sub-module: one always_ff for state and latch, one always_comb for next state and outputs.

Test Plan:
- Client 0 read 0x20, controller model returns 0xABCD1234 with m_ready after 5 cycles → m_read=1, m_addr=0x20 from cycle 1; m_done=1 with m_ready; c0_resp=1 with resp_load=0xABCD1234 exactly one cycle later; c1_resp stays 0.
- Client 1 write 2'b10, addr 0x20, store 0xABCD1234 → m_write=2'b10, m_store=0xABCD1234 held stable until m_ready; c1_resp pulses once.
- Both clients request in the same cycle, fixed priority → client 0 is served first, then client 1 with no intervening idle request loss.
- Same stimulus repeated three times with MEM_ARB_ROUND_ROBIN_EN → grants alternate 0, 1, 0, 1.
- Client 0 changes addr to 0x40 while BUSY → m_addr stays 0x20; assert nrst=0 mid-BUSY → next cycle state IDLE, all outputs 0, no resp pulse.
- Client 0 asserts read and write=2'b11 together → m_write=2'b11, m_read=0.
